// File: rtl/nic_cpu_core_if.sv
// Memory-side bus of nic_cpu_core: program fetch and data load/store,
// each using a req/ack handshake that tolerates wait-stated memories.
interface nic_cpu_core_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 8
);
    logic             imem_req;
    logic [AW-1:0]    imem_addr;
    logic [WIDTH-1:0] imem_rdata;
    logic             imem_ack;
    logic             dmem_req;
    logic             dmem_we;
    logic [AW-1:0]    dmem_addr;
    logic [WIDTH-1:0] dmem_wdata;
    logic [WIDTH-1:0] dmem_rdata;
    logic             dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  imem_rdata, imem_ack, dmem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output imem_rdata, imem_ack, dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/nic_cpu_core.sv
// Multi-cycle accumulator CPU (A/B/X/Q registers, carry flag) with WIDTH-bit data,
// AW-bit addresses and external program/data memories behind req/ack handshakes.
module nic_cpu_core #(
    parameter int            WIDTH    = 8,
    parameter int            AW       = 8,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              resetBar,
    nic_cpu_core_if.master    bus,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    output logic              halted
);
    typedef enum logic [2:0] {FETCH, EXEC, IMM, MEM, HALT} state_e;

    localparam logic [AW-1:0] PC_ONE = AW'(1);

    state_e           state_q;
    logic [AW-1:0]    pc_q;
    logic [7:0]       ir_q;
    logic [WIDTH-1:0] a_q, b_q, x_q, q_q;
    logic             c_q;
    logic             takeJump_q;
    logic             imemReq_q;
    logic             dmemReq_q;
    logic             dmemWe_q;
    logic             outValid_q;
    logic             halted_q;

    logic [3:0]       op;
    logic [WIDTH:0]   addSum, subSum, adcSum;
    logic [WIDTH-1:0] movSrc;
    logic [AW-1:0]    xAddr, immAddr;

    assign op     = ir_q[7:4];
    assign addSum = {1'b0, a_q} + {1'b0, b_q};
    assign subSum = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
    assign adcSum = addSum + {{WIDTH{1'b0}}, c_q};

    always_comb begin
        movSrc = a_q;
        case (ir_q[1:0])
            2'd0:    movSrc = a_q;
            2'd1:    movSrc = b_q;
            2'd2:    movSrc = x_q;
            default: movSrc = q_q;
        endcase
    end

    // X and jump immediates are truncated or zero-extended to the address width.
    if (WIDTH >= AW) begin : gNarrowAddr
        assign xAddr   = x_q[AW-1:0];
        assign immAddr = bus.imem_rdata[AW-1:0];
    end else begin : gWideAddr
        assign xAddr   = {{(AW-WIDTH){1'b0}}, x_q};
        assign immAddr = {{(AW-WIDTH){1'b0}}, bus.imem_rdata};
    end

    assign bus.imem_req   = imemReq_q;
    assign bus.imem_addr  = pc_q;
    assign bus.dmem_req   = dmemReq_q;
    assign bus.dmem_we    = dmemWe_q;
    assign bus.dmem_addr  = xAddr;
    assign bus.dmem_wdata = a_q;
    assign out_data       = q_q;
    assign out_valid      = outValid_q;
    assign halted         = halted_q;

    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            x_q        <= '0;
            q_q        <= '0;
            c_q        <= 1'b0;
            takeJump_q <= 1'b0;
            imemReq_q  <= 1'b0;
            dmemReq_q  <= 1'b0;
            dmemWe_q   <= 1'b0;
            outValid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            outValid_q <= 1'b0;
            case (state_q)
                // A FETCH entered with req low (after reset or an ack) raises it first,
                // so a new request never starts in the cycle of the previous ack.
                FETCH: begin
                    if (!imemReq_q) begin
                        imemReq_q <= 1'b1;
                    end else if (bus.imem_ack) begin
                        ir_q      <= bus.imem_rdata[7:0];
                        pc_q      <= pc_q + PC_ONE;
                        imemReq_q <= 1'b0;
                        state_q   <= EXEC;
                    end
                end
                EXEC: begin
                    state_q   <= FETCH;
                    imemReq_q <= 1'b1;
                    case (op)
                        4'h1, 4'h9, 4'hA, 4'hB: begin
                            state_q    <= IMM;
                            takeJump_q <= (op == 4'h9) || ((op == 4'hA) && (a_q == '0)) ||
                                          ((op == 4'hB) && c_q);
                        end
                        4'h2: begin
                            case (ir_q[3:2])
                                2'd0: a_q <= movSrc;
                                2'd1: b_q <= movSrc;
                                2'd2: x_q <= movSrc;
                                default: begin
                                    q_q        <= movSrc;
                                    outValid_q <= 1'b1;
                                end
                            endcase
                        end
                        4'h3: {c_q, a_q} <= addSum;
                        4'h4: {c_q, a_q} <= subSum;
                        4'h5: {c_q, a_q} <= adcSum;
                        4'h6: begin
                            c_q <= a_q[WIDTH-1];
                            a_q <= {a_q[WIDTH-2:0], 1'b0};
                        end
                        4'h7, 4'h8: begin
                            state_q   <= MEM;
                            imemReq_q <= 1'b0;
                            dmemReq_q <= 1'b1;
                            dmemWe_q  <= op[3];
                        end
                        4'hC: begin
                            q_q        <= a_q;
                            outValid_q <= 1'b1;
                        end
                        4'hD: begin
                            state_q   <= HALT;
                            imemReq_q <= 1'b0;
                            halted_q  <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                IMM: begin
                    if (bus.imem_ack) begin
                        imemReq_q <= 1'b0;
                        state_q   <= FETCH;
                        pc_q      <= takeJump_q ? immAddr : pc_q + PC_ONE;
                        if (op == 4'h1) begin
                            case (ir_q[1:0])
                                2'd0:    a_q <= bus.imem_rdata;
                                2'd1:    b_q <= bus.imem_rdata;
                                2'd2:    x_q <= bus.imem_rdata;
                                default: q_q <= bus.imem_rdata;
                            endcase
                        end
                    end
                end
                MEM: begin
                    if (bus.dmem_ack) begin
                        dmemReq_q <= 1'b0;
                        dmemWe_q  <= 1'b0;
                        state_q   <= FETCH;
                        if (!dmemWe_q) a_q <= bus.dmem_rdata;
                    end
                end
                HALT: ;
                default: state_q <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_nic_cpu_core.sv
// Randomized self-checking bench for nic_cpu_core: an instruction-level interpreter predicts
// fetch addresses, data transfers and OUT values, checked against the DUT every cycle.
module tb_nic_cpu_core;
    logic        clk = 1'b0;
    logic        resetBar = 1'b1;
    logic [7:0]  outData;
    logic        outValid, halted;
    logic [15:0] outData16;
    logic        outValid16, halted16;

    nic_cpu_core_if #(.WIDTH(8), .AW(8)) bus ();
    nic_cpu_core #(.WIDTH(8), .AW(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .resetBar(resetBar), .bus(bus),
        .out_data(outData), .out_valid(outValid), .halted(halted)
    );

    nic_cpu_core_if #(.WIDTH(16), .AW(12)) bus16 ();
    nic_cpu_core #(.WIDTH(16), .AW(12), .RESET_PC(12'h000)) dut16 (
        .clk(clk), .resetBar(resetBar), .bus(bus16),
        .out_data(outData16), .out_valid(outValid16), .halted(halted16)
    );

    always #5 clk = ~clk;

    int          nChecks = 0;
    int          nFails = 0;
    logic [7:0]  imem [256];
    logic [7:0]  dmem [256];
    logic [7:0]  dmemInit [256];
    logic [7:0]  expI [$];
    logic [16:0] expD [$];
    logic [7:0]  expO [$];
    logic [7:0]  obsO [$];
    logic [11:0] obs16 [$];
    bit          rec16 = 1'b0;
    int          iDelayMin = 0, iDelayMax = 0, dDelayMax = 0;
    bit          dHold = 1'b0, spurious = 1'b0;
    int          iWait = 0, iDelay = 0, dWait = 0, dDelay = 0;
    logic [7:0]  iHold, dHoldAddr;
    logic [16:0] e;
    bit          prevOv = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory responders with random wait states; every completed transfer is checked against the model.
    always @(negedge clk) begin
        if (!resetBar) begin
            bus.imem_ack = 1'b0;
            bus.dmem_ack = 1'b0;
            iWait = 0;
            dWait = 0;
            prevOv = 1'b0;
            iDelay = $urandom_range(iDelayMax, iDelayMin);
            dDelay = $urandom_range(dDelayMax, 0);
        end else begin
            if (outValid) begin
                checkOutput("out_valid_gap", {31'd0, prevOv}, 0);
                obsO.push_back(outData);
                checkOutput("out_expected", {31'd0, expO.size() > 0}, 1);
                if (expO.size() > 0) checkOutput("out_data", outData, expO.pop_front());
            end
            prevOv = outValid;
            if (halted) checkOutput("halt_quiet", {bus.imem_req, bus.dmem_req}, 0);

            if (bus.imem_req) begin
                if (iWait == 0) iHold = bus.imem_addr;
                else checkOutput("imem_addr_stable", bus.imem_addr, iHold);
                if (iWait >= iDelay) begin
                    bus.imem_ack = 1'b1;
                    bus.imem_rdata = imem[bus.imem_addr];
                    checkOutput("imem_expected", {31'd0, expI.size() > 0}, 1);
                    if (expI.size() > 0) checkOutput("imem_addr", bus.imem_addr, expI.pop_front());
                    iWait = 0;
                    iDelay = $urandom_range(iDelayMax, iDelayMin);
                end else begin
                    bus.imem_ack = 1'b0;
                    bus.imem_rdata = 8'($urandom);
                    iWait++;
                end
            end else begin
                if (iWait != 0) checkOutput("imem_req_held", {31'd0, bus.imem_req}, 1);
                bus.imem_ack = spurious ? 1'($urandom_range(1, 0)) : 1'b0;
                bus.imem_rdata = 8'($urandom);
                iWait = 0;
            end

            if (bus.dmem_req) begin
                checkOutput("one_bus", {31'd0, bus.imem_req}, 0);
                if (dWait == 0) dHoldAddr = bus.dmem_addr;
                else checkOutput("dmem_addr_stable", bus.dmem_addr, dHoldAddr);
                if (!dHold && dWait >= dDelay) begin
                    bus.dmem_ack = 1'b1;
                    bus.dmem_rdata = dmem[bus.dmem_addr];
                    checkOutput("dmem_expected", {31'd0, expD.size() > 0}, 1);
                    if (expD.size() > 0) begin
                        e = expD.pop_front();
                        checkOutput("dmem_we", {31'd0, bus.dmem_we}, {31'd0, e[16]});
                        checkOutput("dmem_addr", bus.dmem_addr, e[15:8]);
                        if (e[16]) checkOutput("dmem_wdata", bus.dmem_wdata, e[7:0]);
                    end
                    if (bus.dmem_we) dmem[bus.dmem_addr] = bus.dmem_wdata;
                    dWait = 0;
                    dDelay = $urandom_range(dDelayMax, 0);
                end else begin
                    bus.dmem_ack = 1'b0;
                    bus.dmem_rdata = 8'($urandom);
                    dWait++;
                end
            end else begin
                if (dWait != 0) checkOutput("dmem_req_held", {31'd0, bus.dmem_req}, 1);
                bus.dmem_ack = 1'b0;
                dWait = 0;
            end
        end
    end

    function automatic logic [15:0] imem16(input logic [11:0] a);
        case (a)
            12'h000: return 16'hAB90;
            12'h001: return 16'h5FFF;
            12'hFFF: return 16'h3C00;
            default: return 16'h00D0;
        endcase
    endfunction

    // Zero-wait program memory for the wide core; only the first fetch addresses are recorded.
    always @(negedge clk) begin
        bus16.dmem_ack = 1'b0;
        bus16.dmem_rdata = '0;
        if (resetBar && bus16.imem_req) begin
            bus16.imem_ack = 1'b1;
            bus16.imem_rdata = imem16(bus16.imem_addr);
            if (rec16 && obs16.size() < 6) obs16.push_back(bus16.imem_addr);
        end else begin
            bus16.imem_ack = 1'b0;
            bus16.imem_rdata = '0;
        end
    end

    // Instruction-level interpreter: registers as an array, arithmetic on plain integers.
    task automatic buildModel();
        logic [7:0] r [4];
        logic [7:0] dm [256];
        logic [7:0] pc, op, imm;
        bit c, done, take;
        int t;
        for (int i = 0; i < 4; i++) r[i] = 8'h00;
        for (int i = 0; i < 256; i++) dm[i] = dmemInit[i];
        expI.delete(); expD.delete(); expO.delete();
        pc = 8'h00; c = 1'b0; done = 1'b0;
        for (int step = 0; step < 1000 && !done; step++) begin
            expI.push_back(pc);
            op = imem[pc];
            pc = pc + 8'd1;
            case (op[7:4])
                4'h1: begin expI.push_back(pc); r[op[1:0]] = imem[pc]; pc = pc + 8'd1; end
                4'h2: begin
                    r[op[3:2]] = r[op[1:0]];
                    if (op[3:2] == 2'd3) expO.push_back(r[3]);
                end
                4'h3: begin t = int'(r[0]) + int'(r[1]); c = (t > 255); r[0] = 8'(t % 256); end
                4'h4: begin c = (r[0] >= r[1]); r[0] = 8'((int'(r[0]) - int'(r[1]) + 256) % 256); end
                4'h5: begin t = int'(r[0]) + int'(r[1]) + int'(c); c = (t > 255); r[0] = 8'(t % 256); end
                4'h6: begin c = (r[0] >= 8'd128); r[0] = 8'((int'(r[0]) * 2) % 256); end
                4'h7: begin expD.push_back({1'b0, r[2], 8'h00}); r[0] = dm[r[2]]; end
                4'h8: begin expD.push_back({1'b1, r[2], r[0]}); dm[r[2]] = r[0]; end
                4'h9, 4'hA, 4'hB: begin
                    expI.push_back(pc);
                    imm = imem[pc];
                    take = (op[7:4] == 4'h9) || (op[7:4] == 4'hA && r[0] == 8'h00) ||
                           (op[7:4] == 4'hB && c);
                    pc = take ? imm : pc + 8'd1;
                end
                4'hC: begin r[3] = r[0]; expO.push_back(r[3]); end
                4'hD: done = 1'b1;
                default: ;
            endcase
        end
    endtask

    task automatic loadProg(input logic [127:0] p, input int n);
        for (int i = 0; i < 256; i++) imem[i] = 8'hD0;
        for (int i = 0; i < n; i++) imem[i] = p[8*(n-1-i) +: 8];
    endtask

    // Straight-line random program; jumps only go forward to instruction starts, so it always halts.
    task automatic genProgram();
        int pos = 0;
        int n = $urandom_range(40, 12);
        int starts [$];
        int jIdx [$];
        int jSkip [$];
        logic [7:0] rnd;
        int tgt;
        for (int i = 0; i < 256; i++) imem[i] = 8'hD0;
        for (int k = 0; k < n; k++) begin
            rnd = 8'($urandom);
            starts.push_back(pos);
            case ($urandom_range(9, 0))
                0, 1: begin imem[pos] = {6'b000100, rnd[1:0]}; imem[pos+1] = 8'($urandom); pos += 2; end
                2:    begin imem[pos] = {4'h2, rnd[3:0]}; pos += 1; end
                3, 4: begin imem[pos] = {4'($urandom_range(6, 3)), 4'h0}; pos += 1; end
                5:    begin imem[pos] = 8'hC0; pos += 1; end
                6:    begin imem[pos] = rnd[0] ? 8'h80 : 8'h70; pos += 1; end
                7:    begin imem[pos] = rnd[1] ? (rnd[0] ? 8'hF0 : 8'hE0) : 8'h00; pos += 1; end
                default: begin
                    imem[pos] = {4'h9 + 4'($urandom_range(2, 0)), 4'h0};
                    jIdx.push_back(k);
                    jSkip.push_back($urandom_range(3, 0));
                    pos += 2;
                end
            endcase
        end
        starts.push_back(pos);
        for (int j = 0; j < jIdx.size(); j++) begin
            tgt = jIdx[j] + 1 + jSkip[j];
            if (tgt > n) tgt = n;
            imem[starts[jIdx[j]] + 1] = 8'(starts[tgt]);
        end
    endtask

    task automatic applyStimulus(input string name, input int maxCycles);
        int cyc = 0;
        resetBar = 1'b0;
        buildModel();
        obsO.delete();
        for (int i = 0; i < 256; i++) dmem[i] = dmemInit[i];
        repeat (2) @(negedge clk);
        #2 resetBar = 1'b1;
        while (!halted && cyc < maxCycles) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput({name, " halted"}, {31'd0, halted}, 1);
        repeat (3) @(negedge clk);
        checkOutput({name, " imem_left"}, expI.size(), 0);
        checkOutput({name, " dmem_left"}, expD.size(), 0);
        checkOutput({name, " out_left"}, expO.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [11:0] w16Exp [6];
        int cyc;
        w16Exp = '{12'h000, 12'h001, 12'hFFF, 12'h000, 12'h001, 12'hFFF};
        bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0; bus.imem_rdata = '0; bus.dmem_rdata = '0;
        bus16.imem_ack = 1'b0; bus16.dmem_ack = 1'b0; bus16.imem_rdata = '0; bus16.dmem_rdata = '0;
        for (int i = 0; i < 256; i++) dmemInit[i] = 8'($urandom);
        #1 resetBar = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset imem_req", {31'd0, bus.imem_req}, 0);
        checkOutput("reset imem_addr", bus.imem_addr, 0);
        checkOutput("reset dmem_req", {31'd0, bus.dmem_req}, 0);
        checkOutput("reset dmem_we", {31'd0, bus.dmem_we}, 0);
        checkOutput("reset out_valid", {31'd0, outValid}, 0);
        checkOutput("reset halted", {31'd0, halted}, 0);
        checkOutput("reset out_data", outData, 0);
        checkOutput("reset w16 imem_addr", bus16.imem_addr, 0);

        rec16 = 1'b1;
        loadProg(128'h10_05_11_03_30_C0_D0, 7);
        applyStimulus("p1", 500);
        checkOutput("p1 out count", obsO.size(), 1);
        checkOutput("p1 out value", obsO[0], 8'h08);

        checkOutput("w16 fetch count", obs16.size(), 6);
        for (int i = 0; i < 6; i++) checkOutput("w16 fetch addr", obs16[i], w16Exp[i]);
        checkOutput("w16 not halted", {31'd0, halted16}, 0);

        iDelayMin = 3; iDelayMax = 3;
        applyStimulus("p1 wait3", 1000);
        checkOutput("p1 wait3 out count", obsO.size(), 1);
        checkOutput("p1 wait3 out value", obsO[0], 8'h08);
        iDelayMin = 0; iDelayMax = 0;

        loadProg(128'h10_FF_11_01_30_C0_50_C0_D0, 9);
        applyStimulus("p2", 500);
        checkOutput("p2 out count", obsO.size(), 2);
        checkOutput("p2 add value", obsO[0], 8'h00);
        checkOutput("p2 adc value", obsO[1], 8'h02);

        loadProg(128'h10_00_A0_10_C0_D0, 6);
        imem[16] = 8'h10; imem[17] = 8'hAA; imem[18] = 8'hC0;
        applyStimulus("p3 taken", 500);
        checkOutput("p3 taken out", obsO[0], 8'hAA);
        loadProg(128'h10_01_A0_10_C0_D0, 6);
        imem[16] = 8'h10; imem[17] = 8'hAA; imem[18] = 8'hC0;
        applyStimulus("p3 fall", 500);
        checkOutput("p3 fall out", obsO[0], 8'h01);

        loadProg(128'h12_20_10_5A_80_10_00_70_C0_D0, 10);
        for (int d = 0; d <= 2; d++) begin
            dDelayMax = d; iDelayMax = d;
            applyStimulus("p4", 1000);
            checkOutput("p4 stored", dmem[8'h20], 8'h5A);
            checkOutput("p4 loaded", obsO[0], 8'h5A);
        end

        loadProg(128'h12_33_70_C0_D0, 5);
        dHold = 1'b1; dDelayMax = 0; iDelayMax = 1;
        resetBar = 1'b0;
        buildModel();
        repeat (2) @(negedge clk);
        #2 resetBar = 1'b1;
        cyc = 0;
        while (!bus.dmem_req && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("p5 dmem_req seen", {31'd0, bus.dmem_req}, 1);
        repeat (2) @(negedge clk);
        #2 resetBar = 1'b0;
        #1;
        checkOutput("p5 dmem_req async drop", {31'd0, bus.dmem_req}, 0);
        checkOutput("p5 pc reset", bus.imem_addr, 0);
        dHold = 1'b0;
        applyStimulus("p5 restart", 1000);
        checkOutput("p5 loaded", obsO[0], dmemInit[8'h33]);

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 256; i++) dmemInit[i] = 8'($urandom);
            genProgram();
            iDelayMin = 0;
            iDelayMax = $urandom_range(3, 0);
            dDelayMax = $urandom_range(2, 0);
            spurious = t[0];
            applyStimulus("rand", 5000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end
endmodule
